// File: rtl/bit_sampler_pkg.sv
// Shared UART definitions: default framing parameters and receiver state encoding.
package bit_sampler_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rxState_t;

endpackage

// File: rtl/bit_sampler_if.sv
// Serial line in, sampled bits and assembled characters out.
interface bit_sampler_if
    import bit_sampler_pkg::*;
    #(parameter int unsigned DATA_BITS = DATA_BITS_DEF);

    logic                 serialIn;
    logic                 enable;
    logic                 bitReceived;
    logic                 dataBit;
    logic [DATA_BITS-1:0] rxData;
    logic                 dataValid;
    logic                 frameError;

    modport master (
        input  serialIn,
        output enable, bitReceived, dataBit, rxData, dataValid, frameError
    );

    modport slave (
        output serialIn,
        input  enable, bitReceived, dataBit, rxData, dataValid, frameError
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an idle line never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bit_sampler.sv
// Oversampling UART receive sampler: start detection, mid-bit data sampling,
// stop-bit check and character assembly.
module bit_sampler
    import bit_sampler_pkg::*;
    #(
        parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
        parameter int unsigned DATA_BITS  = DATA_BITS_DEF
    ) (
        input  logic          clk,
        input  logic          reset,
        bit_sampler_if.master bus
    );

    localparam int unsigned PW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    localparam logic [PW-1:0] HALF_LAST = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] BIT_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic syncIn;

    rxState_t             state, stateNext;
    logic [PW-1:0]        phase, phaseNext;
    logic [IW-1:0]        index, indexNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic [DATA_BITS-1:0] rxData, rxNext;
    logic                 enable, enNext;
    logic                 bitReceived, brNext;
    logic                 dataBit, dataBitNext;
    logic                 dataValid, dvNext;
    logic                 frameError, feNext;

    sync_2ff lineSync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.serialIn),
        .q     (syncIn)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            index       <= '0;
            shiftReg    <= '0;
            rxData      <= '0;
            enable      <= 1'b0;
            bitReceived <= 1'b0;
            dataBit     <= 1'b0;
            dataValid   <= 1'b0;
            frameError  <= 1'b0;
        end else begin
            state       <= stateNext;
            phase       <= phaseNext;
            index       <= indexNext;
            shiftReg    <= shiftNext;
            rxData      <= rxNext;
            enable      <= enNext;
            bitReceived <= brNext;
            dataBit     <= dataBitNext;
            dataValid   <= dvNext;
            frameError  <= feNext;
        end
    end

    always_comb begin
        stateNext   = state;
        phaseNext   = phase;
        indexNext   = index;
        shiftNext   = shiftReg;
        rxNext      = rxData;
        dataBitNext = dataBit;
        brNext      = 1'b0;
        dvNext      = 1'b0;
        feNext      = 1'b0;

        case (state)
            IDLE: begin
                if (!syncIn) begin
                    stateNext = START;
                    phaseNext = '0;
                end
            end

            START: begin
                if (phase == HALF_LAST) begin
                    phaseNext = '0;
                    if (!syncIn) begin
                        stateNext = DATA;
                        indexNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    phaseNext = phase + 1'b1;
                end
            end

            DATA: begin
                if (phase == BIT_LAST) begin
                    phaseNext   = '0;
                    dataBitNext = syncIn;
                    brNext      = 1'b1;
                    indexNext   = index + 1'b1;
                    // Decoded write avoids indexing the shift register with the wider index.
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (index == IW'(i)) shiftNext[i] = syncIn;
                    end
                    if (index == IDX_LAST) stateNext = STOP;
                end else begin
                    phaseNext = phase + 1'b1;
                end
            end

            STOP: begin
                if (phase == BIT_LAST) begin
                    phaseNext = '0;
                    if (syncIn) begin
                        rxNext    = shiftReg;
                        dvNext    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        feNext    = 1'b1;
                        stateNext = WAIT_HIGH;
                    end
                end else begin
                    phaseNext = phase + 1'b1;
                end
            end

            WAIT_HIGH: begin
                if (syncIn) stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
                phaseNext = '0;
                indexNext = '0;
            end
        endcase

        enNext = (stateNext == DATA) || (stateNext == STOP);
    end

    assign bus.enable      = enable;
    assign bus.bitReceived = bitReceived;
    assign bus.dataBit     = dataBit;
    assign bus.rxData      = rxData;
    assign bus.dataValid   = dataValid;
    assign bus.frameError  = frameError;

endmodule

// File: tb/tb_bit_sampler.sv
// Directed bench for bit_sampler: exact timing of one character, a table of
// characters, and hand-written frame-error, glitch, back-to-back and reset cases.
module tb_bit_sampler;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_sampler_if #(.DATA_BITS(8)) bus ();

    bit_sampler #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Observed activity, sampled 1 time unit after each rising edge.
    int          brCount = 0, dvCount = 0, feCount = 0, enCount = 0;
    int          enRise = -1, enLast = -1;
    int          brCyc[$];
    logic        brBits[$];
    int          dvCyc[$];
    logic [7:0]  dvData[$];
    logic        prevBr = 1'b0, prevDv = 1'b0, prevFe = 1'b0, prevEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.bitReceived) begin
            brCount++;
            brCyc.push_back(cyc);
            brBits.push_back(bus.dataBit);
            check("bitReceivedSingle", {31'd0, prevBr}, 32'd0);
        end
        if (bus.dataValid) begin
            dvCount++;
            dvCyc.push_back(cyc);
            dvData.push_back(bus.rxData);
            check("dataValidSingle", {31'd0, prevDv}, 32'd0);
        end
        if (bus.frameError) begin
            feCount++;
            check("frameErrorSingle", {31'd0, prevFe}, 32'd0);
        end
        if (bus.enable) begin
            enCount++;
            if (!prevEn) enRise = cyc;
            enLast = cyc;
        end
        prevBr = bus.bitReceived;
        prevDv = bus.dataValid;
        prevFe = bus.frameError;
        prevEn = bus.enable;
    end

    // Must be called just after a falling edge; returns at a falling edge so
    // consecutive calls produce characters with no idle gap.
    task automatic sendChar(input logic [7:0] d, input logic stopBit, output int startCyc);
        logic [9:0] frame;
        frame    = {stopBit, d, 1'b0};
        startCyc = cyc;
        for (int i = 0; i < 10; i++) begin
            bus.serialIn = frame[i];
            repeat (OS) @(negedge clk);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".enable"},      {31'd0, bus.enable},      32'd0);
        check({tag, ".bitReceived"}, {31'd0, bus.bitReceived}, 32'd0);
        check({tag, ".dataBit"},     {31'd0, bus.dataBit},     32'd0);
        check({tag, ".rxData"},      {24'd0, bus.rxData},      32'd0);
        check({tag, ".dataValid"},   {31'd0, bus.dataValid},   32'd0);
        check({tag, ".frameError"},  {31'd0, bus.frameError},  32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic [7:0] expRx;
        int         expDv;
        int         expFe;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, br0, dv0, fe0, en0, waited;
        logic [7:0] asm;
        logic [7:0] ref55;

        vecs[0] = '{data: 8'hA3, stopBit: 1'b1, expRx: 8'hA3, expDv: 1, expFe: 0};
        vecs[1] = '{data: 8'h00, stopBit: 1'b1, expRx: 8'h00, expDv: 1, expFe: 0};
        vecs[2] = '{data: 8'hFF, stopBit: 1'b1, expRx: 8'hFF, expDv: 1, expFe: 0};
        vecs[3] = '{data: 8'h80, stopBit: 1'b0, expRx: 8'hFF, expDv: 0, expFe: 1};
        vecs[4] = '{data: 8'h3C, stopBit: 1'b1, expRx: 8'h3C, expDv: 1, expFe: 0};

        bus.serialIn = 1'b1;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Exact timing of 0x55; N = c0 + 3 (two synchronizer stages, then IDLE sees low).
        brCyc.delete(); brBits.delete(); dvCyc.delete(); dvData.delete();
        br0 = brCount;
        sendChar(8'h55, 1'b1, c0);
        n = c0 + 3;
        repeat (10) @(negedge clk);
        check("t55.bitCount", brCount - br0, 8);
        ref55 = 8'h55;
        for (int k = 0; k < 8 && k < brCyc.size(); k++) begin
            check($sformatf("t55.brCyc%0d", k), brCyc[k], n + 24 + 16 * k);
            check($sformatf("t55.bit%0d", k), {31'd0, brBits[k]}, {31'd0, ref55[k]});
        end
        check("t55.dvCount", dvCyc.size(), 1);
        if (dvCyc.size() > 0) begin
            check("t55.dvCyc", dvCyc[0], n + 152);
            check("t55.rxData", {24'd0, dvData[0]}, 32'h55);
        end
        check("t55.enRise", enRise, n + 8);
        check("t55.enLast", enLast, n + 151);

        // Table of characters.
        for (int v = 0; v < 5; v++) begin
            br0 = brCount; dv0 = dvCount; fe0 = feCount;
            brBits.delete();
            sendChar(vecs[v].data, vecs[v].stopBit, c0);
            bus.serialIn = 1'b1;
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d.bits", v), brCount - br0, 8);
            check($sformatf("vec%0d.dv", v), dvCount - dv0, vecs[v].expDv);
            check($sformatf("vec%0d.fe", v), feCount - fe0, vecs[v].expFe);
            check($sformatf("vec%0d.rxData", v), {24'd0, bus.rxData}, {24'd0, vecs[v].expRx});
            asm = '0;
            for (int k = 0; k < 8 && k < brBits.size(); k++) asm[k] = brBits[k];
            check($sformatf("vec%0d.dataBits", v), {24'd0, asm}, {24'd0, vecs[v].data});
        end

        // Frame error with the line held low afterwards: no restart until it goes high.
        dv0 = dvCount; fe0 = feCount;
        sendChar(8'h00, 1'b0, c0);
        en0 = enCount;
        repeat (40) @(negedge clk);
        check("fe.pulse", feCount - fe0, 1);
        check("fe.noValid", dvCount - dv0, 0);
        check("fe.rxKept", {24'd0, bus.rxData}, 32'h3C);
        check("fe.noRestart", enCount - en0, 0);
        bus.serialIn = 1'b1;
        repeat (10) @(negedge clk);
        dv0 = dvCount;
        sendChar(8'h5A, 1'b1, c0);
        repeat (20) @(negedge clk);
        check("fe.recoverValid", dvCount - dv0, 1);
        check("fe.recoverRx", {24'd0, bus.rxData}, 32'h5A);

        // Three-cycle low glitch on an idle line.
        br0 = brCount; dv0 = dvCount; en0 = enCount;
        bus.serialIn = 1'b0;
        repeat (3) @(negedge clk);
        bus.serialIn = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch.enable", enCount - en0, 0);
        check("glitch.bits", brCount - br0, 0);
        check("glitch.valid", dvCount - dv0, 0);

        // Back-to-back characters with no idle gap.
        br0 = brCount; dv0 = dvCount;
        dvData.delete();
        sendChar(8'hA3, 1'b1, c0);
        sendChar(8'h3C, 1'b1, c0);
        repeat (20) @(negedge clk);
        check("b2b.valid", dvCount - dv0, 2);
        check("b2b.bits", brCount - br0, 16);
        if (dvData.size() >= 2) begin
            check("b2b.first", {24'd0, dvData[0]}, 32'hA3);
            check("b2b.second", {24'd0, dvData[1]}, 32'h3C);
        end

        // Reset for one cycle after the 4th bit of 0xFF, then a clean 0x81.
        br0 = brCount; dv0 = dvCount;
        fork
            sendChar(8'hFF, 1'b1, c0);
            begin
                waited = 0;
                while (brCount - br0 < 4 && waited < 400) begin
                    @(negedge clk);
                    waited++;
                end
                check("rst.sawFourBits", {31'd0, (brCount - br0 >= 4)}, 32'd1);
                reset = 1'b1;
                @(negedge clk);
                checkAllZero("rst");
                reset = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("rst.noValid", dvCount - dv0, 0);
        dv0 = dvCount;
        sendChar(8'h81, 1'b1, c0);
        repeat (20) @(negedge clk);
        check("rst.nextValid", dvCount - dv0, 1);
        check("rst.nextRx", {24'd0, bus.rxData}, 32'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
